// File: rtl/dmem_responder_if.sv
// Data-memory port bundle between the RV32 core (master) and dmem_responder (slave).
// FCNT_W must match the responder's fault counter width.
interface dmem_responder_if #(
    parameter int FCNT_W = 8
);
    logic [31:0]       data_addr;
    logic [31:0]       data_write;
    logic [2:0]        MemOp;
    logic              MemWe;
    logic              MemRe;
    logic [31:0]       data_read;
    logic              fault;
    logic [31:0]       fault_addr;
    logic [FCNT_W-1:0] fault_cnt;

    modport master (
        output data_addr, data_write, MemOp, MemWe, MemRe,
        input  data_read, fault, fault_addr, fault_cnt
    );

    modport slave (
        input  data_addr, data_write, MemOp, MemWe, MemRe,
        output data_read, fault, fault_addr, fault_cnt
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: lane-merged stores, extended same-cycle loads, fault capture.
// Optional macro DMEM_POSTED_STORE_EN adds a one-entry posted store with load forwarding.
module dmem_responder #(
    parameter int WORDS  = 16384,
    parameter int FCNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0] mem [WORDS];

    logic [29:0]   widx;
    logic [1:0]    lane;
    logic [AW-1:0] idx;

    assign widx = bus.data_addr[31:2];
    assign lane = bus.data_addr[1:0];
    assign idx  = widx[AW-1:0];

    // size: 0 byte, 1 half, 2 word
    logic       op_ok;
    logic       sext;
    logic [1:0] size;

    always_comb begin
        op_ok = 1'b1;
        sext  = 1'b0;
        size  = 2'd2;
        case (bus.MemOp)
            3'b000:  begin size = 2'd0; sext = 1'b1; end
            3'b001:  begin size = 2'd1; sext = 1'b1; end
            3'b010:  size = 2'd2;
            3'b100:  size = 2'd0;
            3'b101:  size = 2'd1;
            default: op_ok = 1'b0;
        endcase
    end

    logic bad;
    logic do_fault;
    logic do_store;

    assign bad = !op_ok
               || (size == 2'd1 && lane[0])
               || (size == 2'd2 && lane != 2'b00)
               || ({2'b00, widx} >= $unsigned(WORDS));
    assign do_fault = bad && (bus.MemWe || bus.MemRe);
    assign do_store = bus.MemWe && !bad;

    logic [3:0]  wmask;
    logic [31:0] wdata;

    always_comb begin
        wmask = 4'b0000;
        wdata = bus.data_write;
        case (size)
            2'd0: begin
                wmask = 4'b0001 << lane;
                wdata = {4{bus.data_write[7:0]}};
            end
            2'd1: begin
                wmask = 4'b0011 << lane;
                wdata = {2{bus.data_write[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                wdata = bus.data_write;
            end
        endcase
    end

    logic [31:0] arr_word;
    logic [31:0] ld_word;

    assign arr_word = mem[idx];

`ifdef DMEM_POSTED_STORE_EN
    logic          pv;
    logic [AW-1:0] pidx;
    logic [3:0]    pmask;
    logic [31:0]   pdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pv    <= 1'b0;
            pidx  <= '0;
            pmask <= '0;
            pdata <= '0;
        end else begin
            pv <= do_store;
            if (do_store) begin
                pidx  <= idx;
                pmask <= wmask;
                pdata <= wdata;
            end
        end
    end

    // Pending entry drains on the same edge a new store is captured, so the
    // array only ever writes the previously posted word.
    always_ff @(posedge clock) begin
        if (pv) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (pmask[i]) mem[pidx][8*i +: 8] <= pdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        ld_word = arr_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (pv && pidx == idx && pmask[i]) ld_word[8*i +: 8] = pdata[8*i +: 8];
        end
    end
`else
    always_ff @(posedge clock) begin
        if (do_store) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign ld_word = arr_word;
`endif

    logic [31:0] shifted;

    assign shifted = ld_word >> {lane, 3'b000};

    always_comb begin
        bus.data_read = '0;
        if (!bad) begin
            case (size)
                2'd0:    bus.data_read = sext ? {{24{shifted[7]}}, shifted[7:0]}
                                              : {24'h0, shifted[7:0]};
                2'd1:    bus.data_read = sext ? {{16{shifted[15]}}, shifted[15:0]}
                                              : {16'h0, shifted[15:0]};
                default: bus.data_read = ld_word;
            endcase
        end
    end

    logic              fault_q;
    logic [31:0]       fault_addr_q;
    logic [FCNT_W-1:0] fault_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            fault_cnt_q  <= '0;
        end else if (do_fault) begin
            if (fault_cnt_q != '1) fault_cnt_q <= fault_cnt_q + 1'b1;
            if (!fault_q) begin
                fault_q      <= 1'b1;
                fault_addr_q <= bus.data_addr;
            end
        end
    end

    assign bus.fault      = fault_q;
    assign bus.fault_addr = fault_addr_q;
    assign bus.fault_cnt  = fault_cnt_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: scoreboarded load results plus fault-register checks.
// Expectations for the reset-discard case follow DMEM_POSTED_STORE_EN.
module tb_dmem_responder;
    localparam int WORDS  = 16384;
    localparam int FCNT_W = 3;

    logic clock;
    logic reset;

    dmem_responder_if #(.FCNT_W(FCNT_W)) bus ();

    dmem_responder #(
        .WORDS  (WORDS),
        .FCNT_W (FCNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.MemWe      = 1'b0;
        bus.MemRe      = 1'b0;
        bus.MemOp      = 3'b010;
        bus.data_addr  = '0;
        bus.data_write = '0;
    endtask

    task automatic do_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
        bus.MemOp      = op;
        bus.data_addr  = addr;
        bus.data_write = data;
        bus.MemWe      = 1'b1;
        bus.MemRe      = 1'b0;
        @(posedge clock);
        #1;
        idle_bus();
    endtask

    task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic re, input logic [31:0] exp);
        exp_t e;
        exp_t got;
        bus.MemOp     = op;
        bus.data_addr = addr;
        bus.MemWe     = 1'b0;
        bus.MemRe     = re;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
        @(negedge clock);
        got = sbq.pop_front();
        chk(got.tag, bus.data_read, got.exp);
        @(posedge clock);
        #1;
        idle_bus();
    endtask

    task automatic chk_fault(input string tag, input logic f, input logic [31:0] fa, input int fc);
        chk({tag, "_fault"}, {31'h0, bus.fault}, {31'h0, f});
        chk({tag, "_addr"}, bus.fault_addr, fa);
        chk({tag, "_cnt"}, 32'(bus.fault_cnt), fc);
    endtask

    initial begin
        reset = 1'b0;
        idle_bus();
        #12;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk_fault("rst0", 1'b0, 32'h0, 0);

        do_store(3'b010, 32'h0, 32'h13579BDF);
        do_store(3'b010, 32'h400, 32'hCAFEF00D);

        do_store(3'b010, 32'h100, 32'hDEADBEEF);
        do_load("lw_fwd",  3'b010, 32'h100, 1'b1, 32'hDEADBEEF);
        do_load("lb_103",  3'b000, 32'h103, 1'b1, 32'hFFFFFFDE);
        do_load("lbu_103", 3'b100, 32'h103, 1'b1, 32'h000000DE);
        do_load("lh_102",  3'b001, 32'h102, 1'b1, 32'hFFFFDEAD);
        do_load("lhu_100", 3'b101, 32'h100, 1'b1, 32'h0000BEEF);

        do_store(3'b000, 32'h101, 32'h00000012);
        do_load("sb_merge", 3'b010, 32'h100, 1'b1, 32'hDEAD12EF);
        do_store(3'b001, 32'h102, 32'h00008000);
        do_load("sh_merge", 3'b010, 32'h100, 1'b1, 32'h800012EF);
        do_load("lbu_101",  3'b100, 32'h101, 1'b1, 32'h00000012);

        do_store(3'b010, 32'h200, 32'h11111111);
        do_store(3'b010, 32'h204, 32'h22222222);
        do_store(3'b010, 32'h200, 32'h33333333);
        do_load("b2b_200", 3'b010, 32'h200, 1'b1, 32'h33333333);
        do_load("b2b_204", 3'b010, 32'h204, 1'b1, 32'h22222222);

        do_store(3'b010, 32'h0000FFFC, 32'h0BADF00D);
        do_load("top_lw",  3'b010, 32'h0000FFFC, 1'b1, 32'h0BADF00D);
        do_load("top_lhu", 3'b101, 32'h0000FFFE, 1'b1, 32'h00000BAD);
        chk_fault("clean", 1'b0, 32'h0, 0);

        do_store(3'b010, 32'h102, 32'hAAAAAAAA);
        chk_fault("mis_sw", 1'b1, 32'h102, 1);
        do_load("mis_sw_nowr", 3'b010, 32'h100, 1'b1, 32'h800012EF);

        do_load("mis_lh", 3'b001, 32'h301, 1'b1, 32'h0);
        chk_fault("mis_lh", 1'b1, 32'h102, 2);

        do_store(3'b011, 32'h200, 32'h44444444);
        chk_fault("ill_op", 1'b1, 32'h102, 3);
        do_load("ill_nowr", 3'b010, 32'h200, 1'b1, 32'h33333333);

        do_load("oor_idle", 3'b010, 32'(4 * WORDS), 1'b0, 32'h0);
        chk_fault("oor_idle", 1'b1, 32'h102, 3);

        for (int i = 0; i < 5; i++) begin
            do_store(3'b111, 32'h10, 32'h0);
        end
        chk_fault("sat", 1'b1, 32'h102, 7);

        do_store(3'b010, 32'h400, 32'h00000055);
        #2;
        reset = 1'b0;
        #1;
        chk_fault("rst_mid", 1'b0, 32'h0, 0);
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        do_load("rst_keep0", 3'b010, 32'h0, 1'b1, 32'h13579BDF);
`ifdef DMEM_POSTED_STORE_EN
        do_load("rst_discard", 3'b010, 32'h400, 1'b1, 32'hCAFEF00D);
`else
        do_load("rst_discard", 3'b010, 32'h400, 1'b1, 32'h00000055);
`endif
        chk_fault("post_rst", 1'b0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RV32 core: the memory end of the core's `data_addr` / `data_write` / `MemOp` / `MemWe` port. It decodes `MemOp`, performs byte/halfword/word stores with lane merging, and returns sign- or zero-extended load data on `data_read` in the same cycle. It also detects misaligned, illegal and out-of-range accesses, and records the first fault address plus a fault count. A compile-time option adds a one-entry posted-store register with load forwarding.

## Interface
- `WORDS`, default 16384: RAM depth in 32-bit words. Valid byte addresses are 0 .. 4*WORDS-1.
- `FCNT_W`, default 8: width of the saturating fault counter.

Ports (name, direction, width, meaning):
- `clock` input 1: the block's only clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. When low, all registers are cleared immediately.
- `data_addr` input 32: byte address from the core's ALU result.
- `data_write` input 32: store data. Byte/half data sits in the low bits.
- `MemOp` input 3: access type. 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. All other codes are illegal.
- `MemWe` input 1: store strobe.
- `MemRe` input 1: load qualifier. Tie to the core's MemtoReg. Used only for fault detection on loads.
- `data_read` output 32: extended load data. Combinational.
- `fault` output 1: sticky fault flag.
- `fault_addr` output 32: `data_addr` of the first fault.
- `fault_cnt` output FCNT_W: faulting accesses counted, saturating.

## Operation
- Memory is little-endian. Word index = `data_addr[31:2]`. Byte lane = `data_addr[1:0]`.
- An access is bad when any of the following holds:
  - `MemOp` is illegal;
  - half access with `data_addr[0]`=1;
  - word access with `data_addr[1:0]` not 00;
  - word index >= WORDS.
- A bad access counts as a fault only when `MemWe` or `MemRe` is high.
- Loads:
  - Select the byte or half from the lane, then sign- or zero-extend per `MemOp`.
  - A bad access returns 0.
  - `data_read` is always driven, with or without `MemRe`.
- Stores (`MemWe`=1, not bad):
  - Byte mask: lb/lbu → 1 lane; lh/lhu → lanes {a, a+1}; lw → all four lanes.
  - Only masked lanes change. Store data is `data_write[7:0]` or `[15:0]`, replicated into the selected lanes.
  - A bad store writes nothing.
- Fault registers:
  - On a faulting edge, `fault_cnt` increments (saturating at all-ones).
  - If `fault` was 0, `fault` is set and `fault_addr` captures `data_addr`.
  - Later faults never overwrite `fault_addr`. Only `reset` clears it.
- RAM contents are not affected by `reset`.

## Timing
- Reset values: `fault`=0, `fault_addr`=0, `fault_cnt`=0, posted-store valid=0. `data_read` is combinational and has no reset value.
- Load latency is 0 cycles: `data_read` follows `data_addr` / `MemOp` within the same cycle.
- A store is committed on the rising edge of `clock` while `MemWe`=1. With posting enabled, the RAM array itself is written one edge later.
- `data_read` always reflects every store committed at earlier edges, including a posted one. No load ever sees stale data.
- A store and a fault in the same cycle: the fault is recorded and no write happens.
- `reset` asserted mid-cycle clears registers immediately. A pending posted store is discarded.

## Configuration
- Macro `DMEM_POSTED_STORE_EN`.
- Defined:
  - Stores are captured into a one-entry posted register: valid, word index, 4-bit mask, merged data.
  - On each rising edge a pending entry is written into the array. A new store, if present, is then captured; otherwise valid clears.
  - Back-to-back stores therefore drain one per edge.
  - Load path: array word, with the pending entry's masked bytes overlaid when valid and the word index matches. Extension happens after the overlay.
  - The single-port array never sees a write in the same cycle as a merge-read of that word.
- Undefined:
  - No posted register. The masked write goes directly into the array at the rising edge.
  - No forwarding logic.
  - An unflushed store is never lost at reset.
- Externally visible load results are identical in both builds, except for the reset-discard case.

## Test plan
- Reset:
  - Drive `reset`=0 mid-cycle → `fault`=0, `fault_addr`=0, `fault_cnt`=0 immediately.
  - Then release; lw 0x0 returns the prior RAM content.
- Store then extended loads:
  - sw 0xDEADBEEF @0x100; next cycle lw 0x100 → 0xDEADBEEF (forwarded).
  - lb 0x103 → 0xFFFFFFDE; lbu 0x103 → 0x000000DE; lh 0x102 → 0xFFFFDEAD; lhu 0x100 → 0x0000BEEF.
- Partial merge:
  - After the above, sb 0x12 @0x101, then immediately lw 0x100 → 0xDEAD12EF.
  - sh 0x8000 @0x102, then lw 0x100 → 0x800012EF.
- Back-to-back stores:
  - sw 0x11111111 @0x200, then sw 0x22222222 @0x204, then sw 0x33333333 @0x200 on consecutive edges.
  - lw 0x200 → 0x33333333; lw 0x204 → 0x22222222.
- Faults:
  - sw 0xAAAAAAAA @0x102 → word at 0x100 unchanged, `fault`=1, `fault_addr`=0x102, `fault_cnt`=1.
  - lh 0x301 with `MemRe`=1 → `data_read`=0, `fault_addr` still 0x102, `fault_cnt`=2.
  - MemOp 011 with `MemWe`=1 → `fault_cnt`=3.
  - Addr 4*WORDS with `MemRe`=0 and `MemWe`=0 → no count.
- Reset during pending (posted build only):
  - sw 0x55 @0x400, then pull `reset` low before the next edge.
  - After release, lw 0x400 → the old value.
  - In the unposted build, lw 0x400 → 0x00000055.
